// File: rtl/mer_pkg.sv
// mer_pkg: shared definitions for the MER estimator.
//   mer_state_t    - acquisition FSM encoding
//   sat_t          - result of a range check against a signed width
//   sat_check()    - classifies a value as in range / above / below a w-bit signed range
//   acc_abs_w()    - width of the magnitude accumulator for a given configuration
//   acc_err_w()    - width of the squared-error accumulator for a given configuration
//   ACC_ABS_W, ACC_ERR_W - accumulator widths for the default configuration
package mer_pkg;

    localparam int DATA_WIDTH_DEF = 18;
    localparam int LOG2_N_DEF     = 16;

    localparam int ACC_ABS_W = DATA_WIDTH_DEF + LOG2_N_DEF;
    localparam int ACC_ERR_W = 2 * DATA_WIDTH_DEF + LOG2_N_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQ_REF = 2'd1,
        ACQ_ERR = 2'd2,
        DONE    = 2'd3
    } mer_state_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HI   = 2'd1,
        SAT_LO   = 2'd2
    } sat_t;

    function automatic int acc_abs_w(input int dw, input int l2n);
        return dw + l2n;
    endfunction

    function automatic int acc_err_w(input int dw, input int l2n);
        return 2 * dw + l2n;
    endfunction

    // Returns a code rather than the clamped value so callers can pick their
    // own width-exact min/max constants without carrying a wide result.
    function automatic sat_t sat_check(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return SAT_HI;
        if (x < lo) return SAT_LO;
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/ask4_slicer.sv
// ask4_slicer: combinational 4-ASK decision and slicer error.
//   in_reg  - registered signed decision variable
//   thr     - decision threshold between inner and outer levels (2a)
//   a_reg   - inner level magnitude a
//   a3_reg  - outer level magnitude 3a
//   err     - in_reg minus nearest level, saturated to DATA_WIDTH
module ask4_slicer
    import mer_pkg::*;
#(
    parameter int DATA_WIDTH = 18
) (
    input  logic signed [DATA_WIDTH-1:0] in_reg,
    input  logic        [DATA_WIDTH-1:0] thr,
    input  logic        [DATA_WIDTH-1:0] a_reg,
    input  logic        [DATA_WIDTH-1:0] a3_reg,
    output logic signed [DATA_WIDTH-1:0] err
);

    localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic        [DATA_WIDTH-1:0] mag;
    logic        [DATA_WIDTH-1:0] lvl;
    logic signed [DATA_WIDTH:0]   ref_lvl;
    logic signed [DATA_WIDTH:0]   diff;

    always_comb begin
        if (in_reg == S_MIN) begin
            mag = S_MAX;
        end else if (in_reg[DATA_WIDTH-1]) begin
            mag = $unsigned(-in_reg);
        end else begin
            mag = $unsigned(in_reg);
        end

        lvl     = (mag >= thr) ? a3_reg : a_reg;
        // Zero maps to +a, so the reference always shares the input's sign and
        // the difference stays within DATA_WIDTH+1 bits.
        ref_lvl = in_reg[DATA_WIDTH-1] ? -$signed({1'b0, lvl}) : $signed({1'b0, lvl});
        diff    = $signed({in_reg[DATA_WIDTH-1], in_reg}) - ref_lvl;

        case (sat_check(64'(diff), DATA_WIDTH))
            SAT_HI:  err = S_MAX;
            SAT_LO:  err = S_MIN;
            default: err = $signed(diff[DATA_WIDTH-1:0]);
        endcase
    end

endmodule

// File: rtl/mer_estimator.sv
// mer_estimator: two-phase MER statistics for a 4-ASK decision stream.
//   clk        - system clock
//   reset      - asynchronous reset, active low
//   clk_en     - symbol enable, one symbol per asserted cycle
//   start      - single-cycle pulse, accepted in IDLE/DONE only
//   in_data    - signed decision variable (1s17)
//   busy       - high while acquiring
//   valid      - high in DONE, results stable
//   ref_level  - estimated level a (unsigned, 1s17 scaling)
//   err_power  - mean squared slicer error (unsigned, LSB 2^-34)
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for start, outputs from reset
// ACQ_REF | averaging |x| over N symbols to estimate 2a
// ACQ_ERR | averaging squared slicer error over N symbols
// DONE    | results published, valid high, waiting for start
module mer_estimator
    import mer_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int LOG2_N     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic                          start,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          busy,
    output logic                          valid,
    output logic        [DATA_WIDTH-1:0]  ref_level,
    output logic        [2*DATA_WIDTH-1:0] err_power
);

    localparam int ABS_W = acc_abs_w(DATA_WIDTH, LOG2_N);
    localparam int ERR_W = acc_err_w(DATA_WIDTH, LOG2_N);
    localparam int SQ_W  = 2 * DATA_WIDTH;

    localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
    localparam logic [LOG2_N-1:0] CNT_ONE  = {{(LOG2_N-1){1'b0}}, 1'b1};

    mer_state_t                   state;
    logic signed [DATA_WIDTH-1:0] in_reg;
    logic        [LOG2_N-1:0]     cnt;
    logic        [ABS_W-1:0]      abs_acc;
    logic        [ERR_W-1:0]      err_acc;
    logic        [DATA_WIDTH-1:0] thr;
    logic        [DATA_WIDTH-1:0] a_reg;
    logic        [DATA_WIDTH-1:0] a3_reg;

    logic        [DATA_WIDTH-1:0] mag;
    logic        [ABS_W-1:0]      abs_sum;
    logic        [DATA_WIDTH-1:0] mean_next;
    logic        [DATA_WIDTH-1:0] a_next;
    logic        [DATA_WIDTH-1:0] a3_next;
    logic signed [DATA_WIDTH-1:0] err;
    logic        [DATA_WIDTH-1:0] err_abs;
    logic        [SQ_W-1:0]       sq;
    logic        [ERR_W-1:0]      err_sum;

    ask4_slicer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slicer (
        .in_reg (in_reg),
        .thr    (thr),
        .a_reg  (a_reg),
        .a3_reg (a3_reg),
        .err    (err)
    );

    always_comb begin
        if (in_reg == S_MIN) begin
            mag = S_MAX;
        end else if (in_reg[DATA_WIDTH-1]) begin
            mag = $unsigned(-in_reg);
        end else begin
            mag = $unsigned(in_reg);
        end

        abs_sum   = abs_acc + ABS_W'(mag);
        mean_next = DATA_WIDTH'(abs_sum >> LOG2_N);
        a_next    = mean_next >> 1;
        // a3 is built from the freshly computed mean, not the stale a_reg.
        a3_next   = a_next + mean_next;

        // |err| reaches 2^(DATA_WIDTH-1) at most, which still fits unsigned.
        err_abs   = err[DATA_WIDTH-1] ? $unsigned(-err) : $unsigned(err);
        sq        = SQ_W'(err_abs) * SQ_W'(err_abs);
        err_sum   = err_acc + ERR_W'(sq);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_reg    <= '0;
            cnt       <= '0;
            abs_acc   <= '0;
            err_acc   <= '0;
            thr       <= '0;
            a_reg     <= '0;
            a3_reg    <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            ref_level <= '0;
            err_power <= '0;
        end else begin
            if (clk_en) begin
                in_reg <= in_data;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= ACQ_REF;
                        abs_acc <= '0;
                        err_acc <= '0;
                        cnt     <= '0;
                        valid   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                ACQ_REF: begin
                    if (clk_en) begin
                        abs_acc <= abs_sum;
                        if (cnt == CNT_LAST) begin
                            thr    <= mean_next;
                            a_reg  <= a_next;
                            a3_reg <= a3_next;
                            cnt    <= '0;
                            state  <= ACQ_ERR;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end

                ACQ_ERR: begin
                    if (clk_en) begin
                        err_acc <= err_sum;
                        if (cnt == CNT_LAST) begin
                            err_power <= SQ_W'(err_sum >> LOG2_N);
                            ref_level <= a_reg;
                            cnt       <= '0;
                            state     <= DONE;
                            valid     <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mer_estimator.sv
// tb_mer_estimator: scoreboard bench for mer_estimator with N=16.
module tb_mer_estimator;

    localparam int DW   = 18;
    localparam int L2N  = 4;

    typedef struct packed {
        logic [DW-1:0]   rl;
        logic [2*DW-1:0] ep;
    } exp_t;

    localparam exp_t E_CLEAN = '{rl: 18'd8192,  ep: 36'd0};
    localparam exp_t E_OFF   = '{rl: 18'd8192,  ep: 36'd10000};
    localparam exp_t E_SAT   = '{rl: 18'd65535, ep: 36'd4294705156};

    localparam logic signed [DW-1:0] NEG_FS = 18'h20000;

    logic                  clk;
    logic                  reset;
    logic                  clk_en;
    logic                  start;
    logic signed [DW-1:0]  in_data;
    logic                  busy;
    logic                  valid;
    logic [DW-1:0]         ref_level;
    logic [2*DW-1:0]       err_power;

    int   n_checks;
    int   n_fail;
    int   mode;
    int   sidx;
    exp_t sb[$];
    exp_t last_pub;
    logic valid_q;

    mer_estimator #(
        .DATA_WIDTH (DW),
        .LOG2_N     (L2N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .start     (start),
        .in_data   (in_data),
        .busy      (busy),
        .valid     (valid),
        .ref_level (ref_level),
        .err_power (err_power)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] sym(input int m, input int i);
        logic signed [DW-1:0] base;
        case (i % 4)
            0:       base = 18'sd8192;
            1:       base = -18'sd8192;
            2:       base = 18'sd24576;
            default: base = -18'sd24576;
        endcase
        if (m == 2) return NEG_FS;
        if (m == 1) return base + 18'sd100;
        return base;
    endfunction

    task automatic tick(input bit en, input bit st);
        @(negedge clk);
        clk_en = en;
        start  = st;
        if (en) begin
            in_data = sym(mode, sidx);
            sidx++;
        end
        @(posedge clk);
        #1;
    endtask

    // gap: 0 = clk_en every 16th clk, 1 = random gaps, 2 = every clk
    task automatic run_acq(input int m, input int gap, input bit start_in_gap,
                           input bit restart_mid, input exp_t e);
        int n;
        int t;
        bit en;
        mode = m;
        repeat (3) tick(1'b1, 1'b0);
        sb.push_back(e);
        tick(!start_in_gap, 1'b1);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("valid_after_start", 64'(valid), 64'd0);
        chk("ref_hold", 64'(ref_level), 64'(last_pub.rl));
        chk("err_hold", 64'(err_power), 64'(last_pub.ep));
        n = 0;
        t = 0;
        while (n < 32 && t < 4000) begin
            case (gap)
                0:       en = ((t % 16) == 15);
                1:       en = ($urandom_range(0, 2) != 0);
                default: en = 1'b1;
            endcase
            tick(en, restart_mid && n == 20);
            if (en) n++;
            t++;
            if (n < 32) chk("busy_hold", 64'(busy), 64'd1);
            if (en && n == 31) chk("valid_early", 64'(valid), 64'd0);
        end
        chk("en_consumed", 64'(n), 64'd32);
        chk("valid_at_2n", 64'(valid), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (valid && !valid_q) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("ref_level", 64'(ref_level), 64'(e.rl));
                chk("err_power", 64'(err_power), 64'(e.ep));
                last_pub = e;
            end
        end
        valid_q = valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clk_en   = 1'b0;
        start    = 1'b0;
        in_data  = '0;
        mode     = 0;
        sidx     = 0;
        last_pub = '0;
        valid_q  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_ref", 64'(ref_level), 64'd0);
        chk("rst_err", 64'(err_power), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_acq(0, 0, 1'b0, 1'b0, E_CLEAN);
        run_acq(1, 2, 1'b0, 1'b0, E_OFF);
        run_acq(2, 2, 1'b0, 1'b0, E_SAT);
        run_acq(1, 2, 1'b0, 1'b1, E_OFF);

        // reset in the middle of ACQ_REF
        mode = 0;
        repeat (3) tick(1'b1, 1'b0);
        sb.push_back(E_CLEAN);
        tick(1'b1, 1'b1);
        repeat (5) tick(1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_ref", 64'(ref_level), 64'd0);
        chk("midrst_err", 64'(err_power), 64'd0);
        void'(sb.pop_back());
        last_pub = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick(1'b1, 1'b0);
        chk("idle_after_rst", 64'(busy), 64'd0);

        run_acq(0, 2, 1'b0, 1'b0, E_CLEAN);
        run_acq(1, 1, 1'b1, 1'b0, E_OFF);

        repeat (4) tick(1'b1, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mer_estimator.md
# mer_estimator

Measures modulation error ratio (MER) statistics for a 4-ASK decision-variable stream. It sits directly downstream of the MER stimulus DUT and consumes its `decision_variable` output in the symbol clock-enable domain. It runs in two phases:
- estimate the reference level `a` from the mean magnitude;
- slice each symbol to ±a/±3a and average the squared slicer error.

Software forms MER = 10·log10(5a² / err_power).

## Interface
Parameters:
- `DATA_WIDTH`, 18, input sample width, signed 1s17.
- `LOG2_N`, 16, log2 of symbols averaged per phase; N = 2^LOG2_N, legal range 2..20.

Ports:
- `clk`  in  1  system clock, 25 MHz.
- `reset`  in  1  asynchronous, active-low (asserted when 0).
- `clk_en`  in  1  symbol enable; one symbol per asserted cycle.
- `start`  in  1  single-`clk` pulse; sampled on every `clk`, independent of `clk_en`.
- `in_data`  in  DATA_WIDTH  signed decision variable (1s17).
- `busy`  out  1  high in ACQ_REF and ACQ_ERR.
- `valid`  out  1  high in DONE; results stable while high.
- `ref_level`  out  DATA_WIDTH  estimated `a`, unsigned magnitude, 1s17 scaling, MSB always 0.
- `err_power`  out  2*DATA_WIDTH  mean squared error, unsigned, 2s34 scaling, i.e. LSB = 2^-34.

## Operation
- States: IDLE, ACQ_REF, ACQ_ERR, DONE. Reset state is IDLE.
- Reset values: all outputs 0. Accumulators, counter and `in_reg` are 0.
- `in_reg <= in_data` on every `clk_en` in every state. Accumulators only ever use `in_reg`.
- IDLE or DONE with `start`=1 goes to ACQ_REF on the next clk. The same edge does the following:
  - clears both accumulators and the symbol counter;
  - clears `valid`.
- `start` in ACQ_REF or ACQ_ERR is ignored.
- Magnitude: `mag = |in_reg|`. −2^(DATA_WIDTH−1) saturates to 2^(DATA_WIDTH−1)−1.
- ACQ_REF: on each `clk_en`, `abs_acc += mag` and `cnt += 1`.
  - `abs_acc` is unsigned, DATA_WIDTH+LOG2_N bits.
  - On the `clk_en` where `cnt` = N−1 (after the add):
    - `mean_abs <= (abs_acc+mag) >> LOG2_N`;
    - `thr <= mean_abs`, which equals 2a;
    - `a_reg <= mean_abs >> 1`;
    - `a3_reg <= a_reg + mean_abs`, computed from the new value, i.e. 3a;
    - `cnt <= 0`;
    - state goes to ACQ_ERR.
- ACQ_ERR: per `clk_en`:
  - `lvl = (mag >= thr) ? a3_reg : a_reg`;
  - `ref = sign(in_reg) ? −lvl : lvl`;
  - `err = in_reg − ref`, computed in DATA_WIDTH+1 bits, then saturated to DATA_WIDTH;
  - `err_acc += err*err`, with the square as a 2*DATA_WIDTH-bit unsigned value.
  - `err_acc` is unsigned, 2*DATA_WIDTH+LOG2_N bits, with no overflow possible.
  - At `cnt` = N−1:
    - `err_power <= (err_acc+sq) >> LOG2_N`;
    - `ref_level <= a_reg`;
    - state goes to DONE, `valid` = 1.
- DONE holds the outputs until the next `start`. `ref_level` and `err_power` keep their old values during a new acquisition; only `valid` drops.
- `clk_en` low: counter, accumulators and state are frozen. `start` is still accepted in IDLE/DONE.
- Reset mid-acquisition: immediate return to IDLE with all values cleared. No partial result is published.

## Timing
- Input-to-accumulator latency is one `clk_en`. The first symbol accumulated in ACQ_REF is the one captured by the last `clk_en` before entry.
- Each phase consumes exactly N `clk_en` cycles. From `start` to `valid` is 1 clk + 2N `clk_en` cycles.
- `valid` and `busy` are registered and never high together. There is no combinational path from inputs to outputs.
- The squarer may be pipelined by one `clk_en` if it counts exactly N products and `valid` is delayed by the same amount. This option is off by default.

## Structure
- A shared package `mer_pkg` holds:
  - the state encoding;
  - the saturation helper function;
  - the width constants ACC_ABS_W = DATA_WIDTH+LOG2_N and ACC_ERR_W = 2*DATA_WIDTH+LOG2_N.
- One sub-module, `ask4_slicer`: combinational; inputs `in_reg`, `thr`, `a_reg`, `a3_reg`; outputs the saturated `err`.
- The FSM, counter and accumulators stay in the top level.

## Test plan
Bench settings: LOG2_N=4 (N=16), DATA_WIDTH=18.
- Clean levels: 16-symbol repeating pattern {8192, −8192, 24576, −24576}, `clk_en` every 16th clk → `ref_level`=8192, `err_power`=0, `valid` after 1 clk + 32 `clk_en`.
- Offset error: the same pattern +100 on every symbol → `ref_level`=8192 (the magnitude offsets cancel), `err_power`=10000.
- Saturation: all symbols −131072 → `mag`=131071, `mean_abs`=131071, `ref_level`=65535; `err_power` equals the expected saturated-error square, with no wrap.
- `start` pulsed mid-ACQ_ERR → ignored; result identical to the uninterrupted run, `valid` at the same cycle.
- Reset asserted mid-ACQ_REF → all outputs 0, state IDLE. A new `start` then gives a correct result.
- Irregular `clk_en` (random gaps, `start` during a `clk_en`-low cycle) → same results as the clean run; `busy` high throughout the acquisition.
